// File: rtl/tff_ctrl_pkg.sv
// Shared encodings for the toggle-cell bank controller: command opcodes and FSM states.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_LOAD   = 2'b01,
        OP_TOGGLE = 2'b10,
        OP_COUNT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // CLEAR and LOAD always take exactly one step regardless of cmd_steps
    function automatic logic is_single_shot(input op_e op);
        return (op == OP_CLEAR) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/tff_bank_ctrl_if.sv
// Command channel (valid/ready) plus bank status between a command source and the controller.
interface tff_bank_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [CNT_W-1:0] cmd_steps;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_steps,
        input  cmd_ready, q, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_steps,
        output cmd_ready, q, busy, done
    );

endinterface

// File: rtl/tff_cell.sv
// One JK flip-flop wired as a T cell (J = K = t_i), synchronous active-low reset to 0.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // JK characteristic equation with J = K = t_i
    always_comb begin
        q_d = (t_i & ~q_q) | (~t_i & q_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_bank_ctrl.sv
// Command-driven controller that turns clear/load/toggle/count commands into per-cycle
// T vectors for a bank of WIDTH toggle cells.
module tff_bank_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    tff_bank_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, busy_q, done_q;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] tvec_c;
    logic [WIDTH-1:0] t_c;

    // Toggle pattern that moves the bank one step toward the latched command's goal
    always_comb begin
        logic carry;
        tvec_c = '0;
        carry  = 1'b1;
        case (op_q)
            OP_CLEAR:  tvec_c = q_w;
            OP_LOAD:   tvec_c = q_w ^ arg_q;
            OP_TOGGLE: tvec_c = arg_q;
            OP_COUNT: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    tvec_c[i] = carry;
                    carry     = carry & q_w[i];
                end
            end
            default:   tvec_c = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        t_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && ready_q) begin
                    op_d    = op_e'(bus.cmd_op);
                    arg_d   = bus.cmd_arg;
                    cnt_d   = is_single_shot(op_e'(bus.cmd_op)) ? CNT_W'(1) : bus.cmd_steps;
                    state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                t_c   = tvec_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered decodes of the next state so they align with state_q
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLEAR;
            arg_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t_i   (t_c[i]),
            .q_o   (q_w[i])
        );
    end

    assign bus.q         = q_w;
    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Self-checking bench for tff_bank_ctrl: directed scenarios plus random commands checked
// against a value-level model of the bank (clear -> 0, load -> arg, toggle -> xor, count -> +1).
module tb_tff_bank_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] q_m;

    always #5 clk = ~clk;

    tff_bank_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

    tff_bank_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] ref_step(input logic [1:0] op, input logic [7:0] arg,
                                            input logic [7:0] q);
        case (op)
            2'd0:    return 8'h00;
            2'd1:    return arg;
            2'd2:    return q ^ arg;
            default: return q + 8'd1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge, then withdraw cmd_valid
    task automatic issue(input logic [1:0] op, input logic [7:0] arg, input logic [7:0] steps);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_steps = steps;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: q=%h ready=%b busy=%b done=%b want q=00 ready=1 busy=0 done=0",
                     bus.q, bus.cmd_ready, bus.busy, bus.done);
        end
        q_m = 8'h00;
    endtask

    task automatic test_load();
        issue(2'd1, 8'hA5, 8'h00);
        vectors++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.q !== 8'h00 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_accept: busy=%b ready=%b q=%h done=%b want 1 0 00 0",
                     bus.busy, bus.cmd_ready, bus.q, bus.done);
        end
        tick();
        vectors++;
        if (bus.q !== 8'hA5 || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL load_e1: q=%h done=%b want q=a5 done=1", bus.q, bus.done);
        end
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_e2: ready=%b done=%b busy=%b want 1 0 0",
                     bus.cmd_ready, bus.done, bus.busy);
        end
        q_m = 8'hA5;
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_q;
        int         dones;
        issue(2'd1, 8'hFE, 8'h00);
        tick();
        tick();
        exp_q = 8'hFE;
        dones = 0;
        issue(2'd3, 8'h77, 8'd5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_q = exp_q + 8'd1;
            dones += (bus.done === 1'b1) ? 1 : 0;
            vectors++;
            if (bus.q !== exp_q || bus.done !== (k == 5)) begin
                miscompares++;
                $display("FAIL count_step%0d: q=%h done=%b want q=%h done=%b",
                         k, bus.q, bus.done, exp_q, (k == 5));
            end
        end
        tick();
        vectors++;
        if (dones != 1 || bus.cmd_ready !== 1'b1 || bus.q !== 8'h03) begin
            miscompares++;
            $display("FAIL count_end: done_pulses=%0d ready=%b q=%h want 1 1 03",
                     dones, bus.cmd_ready, bus.q);
        end
        q_m = 8'h03;
    endtask

    task automatic test_toggle();
        logic [7:0] exp_seq [3];
        int         busy_cycles;
        exp_seq = '{8'h0F, 8'h00, 8'h0F};
        issue(2'd0, 8'hFF, 8'd9);
        tick();
        tick();
        issue(2'd2, 8'h0F, 8'd3);
        busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            busy_cycles += (bus.busy === 1'b1) ? 1 : 0;
            vectors++;
            if (bus.q !== exp_seq[k]) begin
                miscompares++;
                $display("FAIL toggle_step%0d: q=%h want %h", k + 1, bus.q, exp_seq[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            busy_cycles += (bus.busy === 1'b1) ? 1 : 0;
        end
        vectors++;
        if (busy_cycles != 4) begin
            miscompares++;
            $display("FAIL toggle_busy: busy_cycles=%0d want 4", busy_cycles);
        end
        q_m = 8'h0F;
    endtask

    task automatic test_zero_steps();
        issue(2'd1, 8'h3C, 8'h00);
        tick();
        tick();
        issue(2'd2, 8'hFF, 8'd0);
        vectors++;
        if (bus.done !== 1'b1 || bus.q !== 8'h3C || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_accept: done=%b q=%h busy=%b want 1 3c 1", bus.done, bus.q, bus.busy);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.q !== 8'h3C) begin
            miscompares++;
            $display("FAIL zero_after: done=%b ready=%b q=%h want 0 1 3c",
                     bus.done, bus.cmd_ready, bus.q);
        end
        q_m = 8'h3C;
    endtask

    task automatic test_reset_abort();
        issue(2'd3, 8'h00, 8'd10);
        tick();
        vectors++;
        if (bus.q !== 8'h3D) begin
            miscompares++;
            $display("FAIL abort_step1: q=%h want 3d", bus.q);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: q=%h busy=%b done=%b want 00 0 0", bus.q, bus.busy, bus.done);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_release: ready=%b done=%b busy=%b q=%h want 1 0 0 00",
                     bus.cmd_ready, bus.done, bus.busy, bus.q);
        end
        q_m = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q;
        issue(2'd1, 8'h5A, 8'h00);
        tick();
        tick();
        exp_q = 8'h5A;
        issue(2'd2, 8'hFF, 8'd3);
        // Pending CLEAR held on the bus while the toggle runs; arg scrambled mid-run
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'h00;
        bus.cmd_steps = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            exp_q = exp_q ^ 8'hFF;
            bus.cmd_arg = 8'($urandom);
            vectors++;
            if (bus.q !== exp_q) begin
                miscompares++;
                $display("FAIL b2b_step%0d: q=%h want %h", k, bus.q, exp_q);
            end
        end
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.q !== 8'hA5 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: ready=%b q=%h busy=%b want 1 a5 0", bus.cmd_ready, bus.q, bus.busy);
        end
        tick();
        bus.cmd_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.q !== 8'hA5) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b q=%h want 1 a5", bus.busy, bus.q);
        end
        tick();
        vectors++;
        if (bus.q !== 8'h00 || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_clear: q=%h done=%b want 00 1", bus.q, bus.done);
        end
        tick();
        q_m = 8'h00;
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] steps;
        int         n;
        int         guard;
        for (int c = 0; c < 40; c++) begin
            op    = 2'($urandom);
            arg   = 8'($urandom);
            steps = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(20, 40))
                                                : 8'($urandom_range(0, 6));
            n     = (op < 2'd2) ? 1 : int'(steps);
            guard = 0;
            while (bus.cmd_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) begin
                vectors++;
                miscompares++;
                $display("FAIL rnd_ready_timeout: cmd %0d ready=%b want 1", c, bus.cmd_ready);
            end
            issue(op, arg, steps);
            if (n == 0) begin
                vectors++;
                if (bus.done !== 1'b1 || bus.q !== q_m) begin
                    miscompares++;
                    $display("FAIL rnd_zero: cmd %0d done=%b q=%h want 1 %h", c, bus.done, bus.q, q_m);
                end
            end
            for (int k = 1; k <= n; k++) begin
                tick();
                q_m = ref_step(op, arg, q_m);
                vectors++;
                if (bus.q !== q_m || bus.done !== (k == n) || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_step: cmd %0d op=%0d step %0d/%0d q=%h done=%b busy=%b want q=%h done=%b busy=1",
                             c, op, k, n, bus.q, bus.done, bus.busy, q_m, (k == n));
                end
            end
            tick();
            vectors++;
            if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.q !== q_m) begin
                miscompares++;
                $display("FAIL rnd_end: cmd %0d ready=%b done=%b q=%h want 1 0 %h",
                         c, bus.cmd_ready, bus.done, bus.q, q_m);
            end
            if ($urandom_range(0, 2) == 0) tick();
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_arg   = 8'h00;
        bus.cmd_steps = 8'h00;
        q_m           = 8'h00;
        test_reset();
        test_load();
        test_count_wrap();
        test_toggle();
        test_zero_steps();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
